// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU core.
// Contents: op_t operation codes, state_t FSM states, flag bit indices,
// and a helper that classifies operations needing the iterative unit.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_MUL = 3'b110,
      OP_DIV = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned FLAG_W  = 5;
   localparam int unsigned FLAG_Z  = 0;
   localparam int unsigned FLAG_N  = 1;
   localparam int unsigned FLAG_C  = 2;
   localparam int unsigned FLAG_V  = 3;
   localparam int unsigned FLAG_DZ = 4;

   // MUL always iterates; DIV iterates unless the divisor is zero.
   function automatic logic is_iterative(op_t op, logic b_zero);
      return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
   endfunction

endpackage

// File: rtl/seq_alu_core_if.sv
// Request/response bundle between the operand unpacker, the ALU core and
// the result packer.
// Request:  in_valid, in_ready, op, a, b
// Response: out_valid, out_ready, result (2*WIDTH), flags {DZ,V,C,N,Z}
// master = requester/consumer side, slave = the ALU core.
interface seq_alu_core_if #(
   parameter int unsigned WIDTH = 4
) ();
   import alu_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   op_t                    op;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WIDTH-1:0]     result;
   logic [FLAG_W-1:0]      flags;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, flags
   );

endinterface

// File: rtl/alu_muldiv_unit.sv
// Iterative unsigned multiply (shift-add, LSB first) and restoring divide
// (MSB first), one bit per cycle over WIDTH iterations. The first iteration
// runs on the start edge, so done_o pulses for one cycle once all WIDTH
// iterations have completed (WIDTH-1 cycles after start).
// Ports: clk, rst (sync, active-high), start_i, is_div_i, a_i, b_i,
//        busy_o, done_o, product_o, quotient_o, remainder_o.
module alu_muldiv_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               is_div_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o,
   output logic [WIDTH-1:0]   quotient_o,
   output logic [WIDTH-1:0]   remainder_o
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   // hi holds partial product / partial remainder; lo holds the multiplier
   // being consumed (MUL) or the dividend shifting out while quotient bits
   // shift in (DIV).
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 is_div_q, is_div_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;

   // One iteration of either algorithm on the {hi, lo} pair.
   function automatic logic [2*WIDTH-1:0] step(logic div, logic [WIDTH-1:0] hi,
                                               logic [WIDTH-1:0] lo, logic [WIDTH-1:0] d);
      logic [WIDTH:0] sum;
      logic [WIDTH:0] shl;
      logic [WIDTH:0] trial;
      logic           qbit;
      sum   = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
      shl   = {hi, lo[WIDTH-1]};
      trial = shl - {1'b0, d};
      // Partial remainder stays below the divisor, so a set MSB means negative.
      qbit  = !trial[WIDTH];
      if (!div) begin
         return {sum, lo[WIDTH-1:1]};
      end
      return {(qbit ? trial[WIDTH-1:0] : shl[WIDTH-1:0]), lo[WIDTH-2:0], qbit};
   endfunction

   // Next-state: load-and-first-step on start, then one step per cycle.
   always_comb begin
      busy_d   = busy_q;
      done_d   = 1'b0;
      is_div_d = is_div_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dvs_d    = dvs_q;
      if (start_i) begin
         {hi_d, lo_d} = step(is_div_i, '0, a_i, b_i);
         busy_d       = 1'b1;
         is_div_d     = is_div_i;
         cnt_d        = CW'(WIDTH - 1);
         dvs_d        = b_i;
      end else if (busy_q) begin
         {hi_d, lo_d} = step(is_div_q, hi_q, lo_q, dvs_q);
         cnt_d        = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // Iteration state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         is_div_q <= 1'b0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         dvs_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         done_q   <= done_d;
         is_div_q <= is_div_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dvs_q    <= dvs_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign product_o   = {hi_q, lo_q};
   assign quotient_o  = lo_q;
   assign remainder_o = hi_q;

endmodule

// File: rtl/seq_alu_core.sv
// Multi-cycle ALU: one operation per valid/ready transaction. ADD/SUB/logic/
// SHL and divide-by-zero complete in one cycle; MUL and DIV run WIDTH
// iterations in alu_muldiv_unit. Result and flags are registered and held
// until the consumer accepts them.
// Ports: clk, rst (sync, active-high), bus (seq_alu_core_if.slave):
//        in_valid/in_ready/op/a/b request, out_valid/out_ready/result/flags
//        response.
module seq_alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   seq_alu_core_if.slave bus
);

   localparam int unsigned RW  = 2 * WIDTH;
   localparam int unsigned W1  = WIDTH + 1;
   localparam int unsigned SW  = $clog2(WIDTH);
   localparam int unsigned MSB = WIDTH - 1;

   state_t              state_q, state_d;
   op_t                 op_q;
   logic [RW-1:0]       result_q, result_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;

   logic                accept_c;
   logic                b_zero_c;
   logic                md_start_c;
   logic                md_busy_c;
   logic                md_done_c;
   logic [RW-1:0]       md_product_c;
   logic [WIDTH-1:0]    md_quot_c;
   logic [WIDTH-1:0]    md_rem_c;
   logic [RW-1:0]       md_result_c;

   logic [W1-1:0]       add_sum_c;
   logic [W1-1:0]       sub_sum_c;
   logic [WIDTH-1:0]    shl_c;
   logic [RW-1:0]       sc_result_c;
   logic                sc_carry_c;
   logic                sc_ovf_c;

   assign accept_c   = (state_q == IDLE) && bus.in_valid;
   assign b_zero_c   = (bus.b == '0);
   assign md_start_c = accept_c && is_iterative(bus.op, b_zero_c);

   // Flags derived from the final result word.
   function automatic logic [FLAG_W-1:0] make_flags(op_t op, logic [RW-1:0] res,
                                                    logic c, logic v, logic dz);
      logic [FLAG_W-1:0] f;
      f          = '0;
      f[FLAG_Z]  = (res == '0);
      case (op)
         OP_MUL:  f[FLAG_N] = res[RW-1];
         OP_DIV:  f[FLAG_N] = 1'b0;
         default: f[FLAG_N] = res[MSB];
      endcase
      f[FLAG_C]  = c;
      f[FLAG_V]  = v;
      f[FLAG_DZ] = dz;
      return f;
   endfunction

   alu_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
      .clk         (clk),
      .rst         (rst),
      .start_i     (md_start_c),
      .is_div_i    (bus.op == OP_DIV),
      .a_i         (bus.a),
      .b_i         (bus.b),
      .busy_o      (md_busy_c),
      .done_o      (md_done_c),
      .product_o   (md_product_c),
      .quotient_o  (md_quot_c),
      .remainder_o (md_rem_c)
   );

   assign md_result_c = (op_q == OP_DIV) ? {md_rem_c, md_quot_c} : md_product_c;

   // Single-cycle datapath, including the divide-by-zero result.
   always_comb begin
      // SUB carry is a+~b+1, so carry set means no borrow.
      add_sum_c   = {1'b0, bus.a} + {1'b0, bus.b};
      sub_sum_c   = {1'b0, bus.a} + {1'b0, ~bus.b} + W1'(1);
      shl_c       = bus.a << bus.b[SW-1:0];
      sc_result_c = '0;
      sc_carry_c  = 1'b0;
      sc_ovf_c    = 1'b0;
      case (bus.op)
         OP_ADD: begin
            sc_result_c = RW'(add_sum_c);
            sc_carry_c  = add_sum_c[WIDTH];
            sc_ovf_c    = (bus.a[MSB] == bus.b[MSB]) && (add_sum_c[MSB] != bus.a[MSB]);
         end
         OP_SUB: begin
            sc_result_c = RW'(sub_sum_c);
            sc_carry_c  = sub_sum_c[WIDTH];
            sc_ovf_c    = (bus.a[MSB] != bus.b[MSB]) && (sub_sum_c[MSB] != bus.a[MSB]);
         end
         OP_AND:  sc_result_c = RW'(bus.a & bus.b);
         OP_OR:   sc_result_c = RW'(bus.a | bus.b);
         OP_XOR:  sc_result_c = RW'(bus.a ^ bus.b);
         OP_SHL:  sc_result_c = RW'(shl_c);
         OP_DIV:  sc_result_c = {bus.a, {WIDTH{1'b1}}};
         default: sc_result_c = '0;
      endcase
   end

   // FSM next-state and output-register next values.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (md_start_c) begin
                  state_d = BUSY;
               end else begin
                  result_d = sc_result_c;
                  flags_d  = make_flags(bus.op, sc_result_c, sc_carry_c, sc_ovf_c,
                                        (bus.op == OP_DIV) && b_zero_c);
                  state_d  = DONE;
               end
            end
         end
         BUSY: begin
            if (md_done_c) begin
               result_d = md_result_c;
               flags_d  = make_flags(op_q, md_result_c, 1'b0, 1'b0, 1'b0);
               state_d  = DONE;
            end else if (!md_busy_c) begin
               // Unit idle without a pending result: never strand in BUSY.
               state_d = IDLE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, captured opcode and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= OP_ADD;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         if (accept_c) begin
            op_q <= bus.op;
         end
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// Scoreboard bench for seq_alu_core at WIDTH=4 and WIDTH=8.
module tb_seq_alu_core;
   import alu_pkg::*;

   typedef struct {
      longint     res;
      logic [4:0] flags;
      int         acc;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   rdy_mode = 0;
   exp_t q4[$];
   exp_t q8[$];
   exp_t mon_e;
   logic prev4 = 1'b0;
   logic prev8 = 1'b0;

   seq_alu_core_if #(.WIDTH(4)) bus4 ();
   seq_alu_core_if #(.WIDTH(8)) bus8 ();

   seq_alu_core #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   seq_alu_core #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model from the operation table with plain integer arithmetic.
   function automatic exp_t model(int w, int op, longint a, longint b, int acc);
      exp_t   e;
      longint mask, half, sa, sb, sr, res;
      int     sh;
      logic   c, v, n, dz;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      sa   = (a >= half) ? a - (mask + 1) : a;
      sb   = (b >= half) ? b - (mask + 1) : b;
      c = 1'b0; v = 1'b0; dz = 1'b0; res = 0;
      case (op)
         0: begin res = a + b; c = (res > mask); sr = sa + sb;
                  v = (sr >= half) || (sr < -half); end
         1: begin c = (a >= b); res = ((a - b) & mask) | (c ? mask + 1 : 0);
                  sr = sa - sb; v = (sr >= half) || (sr < -half); end
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         5: begin sh = int'(b & ((longint'(1) << $clog2(w)) - 1));
                  res = (a << sh) & mask; end
         6: res = a * b;
         default: begin
            if (b == 0) begin res = (a << w) | mask; dz = 1'b1; end
            else res = ((a % b) << w) | (a / b);
         end
      endcase
      n = (op <= 5) ? res[w-1] : ((op == 6) ? res[2*w-1] : 1'b0);
      e.res   = res;
      e.flags = {dz, v, c, n, (res == 0)};
      e.acc   = acc;
      e.lat   = (op == 6 || (op == 7 && b != 0)) ? w + 1 : 1;
      return e;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Wait for in_ready, push the expectation, present one request for one edge.
   task automatic issue(input int w, input int op, input longint a, input longint b);
      int   n;
      logic rdy;
      n = 0;
      @(negedge clk);
      rdy = (w == 4) ? bus4.in_ready : bus8.in_ready;
      while (rdy !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
         rdy = (w == 4) ? bus4.in_ready : bus8.in_ready;
      end
      if (rdy !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout w=%0d: in_ready stayed low for %0d cycles", w, n);
      end else if (w == 4) begin
         q4.push_back(model(4, op, a, b, cyc + 1));
         bus4.in_valid = 1'b1; bus4.op = op_t'(3'(op));
         bus4.a = 4'(a); bus4.b = 4'(b);
         @(negedge clk);
         bus4.in_valid = 1'b0;
      end else begin
         q8.push_back(model(8, op, a, b, cyc + 1));
         bus8.in_valid = 1'b1; bus8.op = op_t'(3'(op));
         bus8.a = 8'(a); bus8.b = 8'(b);
         @(negedge clk);
         bus8.in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q4.size() != 0 || q8.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (q4.size() != 0 || q8.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d/%0d results still pending", q4.size(), q8.size());
      end
   endtask

   function automatic longint rnd_opnd(int w);
      int unsigned r;
      r = $urandom_range(0, 5);
      if (r == 0) return 0;
      if (r == 1) return (longint'(1) << w) - 1;
      return longint'($urandom_range(0, (1 << w) - 1));
   endfunction

   // out_ready: 0 = always high, 1 = random, 2 = held low.
   always @(negedge clk) begin
      #1;
      case (rdy_mode)
         0:       begin bus4.out_ready = 1'b1; bus8.out_ready = 1'b1; end
         1:       begin bus4.out_ready = 1'($urandom_range(0, 1));
                        bus8.out_ready = 1'($urandom_range(0, 1)); end
         default: begin bus4.out_ready = 1'b0; bus8.out_ready = 1'b0; end
      endcase
   end

   // Monitor: compare each newly presented result against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && bus4.out_valid && !prev4) begin
         if (q4.size() == 0) begin
            checks++; failures++;
            $display("FAIL out4_unexpected: result=0x%0h with no pending op", bus4.result);
         end else begin
            mon_e = q4.pop_front();
            chk("w4_result", 64'(bus4.result), mon_e.res);
            chk("w4_flags", 64'(bus4.flags), 64'(mon_e.flags));
            chk("w4_latency", 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
         end
      end
      if (!rst && bus8.out_valid && !prev8) begin
         if (q8.size() == 0) begin
            checks++; failures++;
            $display("FAIL out8_unexpected: result=0x%0h with no pending op", bus8.result);
         end else begin
            mon_e = q8.pop_front();
            chk("w8_result", 64'(bus8.result), mon_e.res);
            chk("w8_flags", 64'(bus8.flags), 64'(mon_e.flags));
            chk("w8_latency", 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
         end
      end
      prev4 = bus4.out_valid;
      prev8 = bus8.out_valid;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t stall_e;
      bus4.in_valid = 1'b0; bus4.op = OP_ADD; bus4.a = '0; bus4.b = '0;
      bus8.in_valid = 1'b0; bus8.op = OP_ADD; bus8.a = '0; bus8.b = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready4", 64'(bus4.in_ready), 64'd1);
      chk("rst_out_valid4", 64'(bus4.out_valid), 64'd0);
      chk("rst_result4", 64'(bus4.result), 64'd0);
      chk("rst_flags4", 64'(bus4.flags), 64'd0);
      chk("rst_in_ready8", 64'(bus8.in_ready), 64'd1);
      chk("rst_out_valid8", 64'(bus8.out_valid), 64'd0);
      chk("rst_result8", 64'(bus8.result), 64'd0);
      chk("rst_flags8", 64'(bus8.flags), 64'd0);
      rst = 1'b0;

      // Directed cases from the operation table.
      issue(4, 0, 7, 9);
      issue(4, 1, 3, 5);
      issue(4, 1, 8, 1);
      issue(4, 6, 15, 15);
      for (int i = 0; i < 5; i++) begin
         chk("mul_in_ready_low", 64'(bus4.in_ready), 64'd0);
         @(negedge clk);
      end
      issue(4, 7, 9, 0);
      issue(4, 7, 15, 4);
      issue(4, 5, 11, 13);
      issue(4, 5, 1, 7);
      issue(4, 1, 5, 5);
      issue(8, 7, 200, 7);
      issue(8, 7, 5, 0);
      issue(8, 6, 255, 255);
      issue(8, 0, 127, 1);
      drain();

      // Hold the response: output stable, no new accept, in_ready after release.
      rdy_mode = 2;
      stall_e = model(4, 0, 7, 9, 0);
      issue(4, 0, 7, 9);
      for (int i = 0; i < 10; i++) begin
         chk("stall_out_valid", 64'(bus4.out_valid), 64'd1);
         chk("stall_in_ready", 64'(bus4.in_ready), 64'd0);
         chk("stall_result", 64'(bus4.result), stall_e.res);
         chk("stall_flags", 64'(bus4.flags), 64'(stall_e.flags));
         bus4.in_valid = 1'b1; bus4.op = OP_SUB; bus4.a = 4'd2; bus4.b = 4'd1;
         @(negedge clk);
      end
      bus4.in_valid = 1'b0;
      rdy_mode = 0;
      @(negedge clk);
      chk("release_in_ready", 64'(bus4.in_ready), 64'd1);
      chk("release_out_valid", 64'(bus4.out_valid), 64'd0);

      // Reset in the third BUSY cycle of a MUL drops the operation.
      issue(4, 6, 13, 11);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      q4.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("post_rst_in_ready", 64'(bus4.in_ready), 64'd1);
      chk("post_rst_out_valid", 64'(bus4.out_valid), 64'd0);
      repeat (8) @(negedge clk);
      chk("dropped_op_no_output", 64'(bus4.out_valid), 64'd0);
      issue(4, 0, 1, 1);
      drain();

      // Randomized traffic on both widths with random back-pressure.
      rdy_mode = 1;
      fork
         for (int i = 0; i < 120; i++)
            issue(4, int'($urandom_range(0, 7)), rnd_opnd(4), rnd_opnd(4));
         for (int j = 0; j < 80; j++)
            issue(8, int'($urandom_range(0, 7)), rnd_opnd(8), rnd_opnd(8));
      join
      drain();
      rdy_mode = 0;
      repeat (4) @(negedge clk);

      chk("q4_empty", 64'(q4.size()), 64'd0);
      chk("q8_empty", 64'(q8.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
